// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Advance a pointer by one entry, wrapping at an arbitrary depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FIFO with arbitrary depth, STD/FWFT read modes,
// programmable almost-full/empty thresholds, flush and sticky error flags.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  parameter  fifo_mode_e  MODE  = FIFO_STD,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             wr_ack_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  input  logic [LW-1:0]    af_thresh_i,
  input  logic [LW-1:0]    ae_thresh_i,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [1:0]       err_sticky_o,
  input  logic             err_clr_i
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ack_q, overflow_q, underflow_q;
  logic [1:0]       err_q, err_d;
  logic             wr_acc, rd_acc, wr_rej, rd_rej;
  logic [WIDTH-1:0] mem_rdata;

  // Status decoded from the registered level.
  assign full_o         = (level_q == LVL_MAX);
  assign empty_o        = (level_q == '0);
  assign almost_full_o  = (level_q >= af_thresh_i);
  assign almost_empty_o = (level_q <= ae_thresh_i);
  assign level_o        = level_q;

  // Accept/reject decisions; a flush swallows both requests silently.
  assign wr_acc = wr_en_i && !full_o  && !flush_i;
  assign rd_acc = rd_en_i && !empty_o && !flush_i;
  assign wr_rej = wr_en_i &&  full_o  && !flush_i;
  assign rd_rej = rd_en_i &&  empty_o && !flush_i;

  // Next pointers, level and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = (err_q & ~{2{err_clr_i}}) | {wr_rej, rd_rej};
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (rd_acc) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
      if (wr_acc && !rd_acc)      level_d = level_q + LW'(1);
      else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
    end
  end

  // Control state and event pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      err_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_rej;
      underflow_q <= rd_rej;
      err_q       <= err_d;
    end
  end

  assign wr_ack_o     = wr_ack_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;
  assign err_sticky_o = err_q;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head word is presented directly; zero while empty.
    assign rd_data_o  = empty_o ? '0 : mem_rdata;
    assign rd_valid_o = !empty_o;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    // Capture the head word on an accepted read, hold otherwise.
    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) rd_data_d = mem_rdata;
    end

    // Registered read data stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_acc;
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: three instances (STD depth 8, STD depth 6,
// FWFT depth 8) share one stimulus stream and a queue-style reference model.
module tb_fifo_prog;
  import fifo_pkg::*;

  localparam int NI = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [15:0] wr_data_i = 16'h0;
  logic [3:0]  af8 = 4'd6, ae8 = 4'd2;
  logic [2:0]  af6 = 3'd4, ae6 = 3'd1;

  logic [15:0] rdat  [NI];
  logic        rval  [NI];
  logic        ack   [NI];
  logic        full  [NI];
  logic        empty [NI];
  logic        afl   [NI];
  logic        ael   [NI];
  logic        ovf   [NI];
  logic        unf   [NI];
  logic [1:0]  stk   [NI];
  logic [3:0]  lvl0, lvl2;
  logic [2:0]  lvl1;

  int errors = 0;
  int checks = 0;
  int ack_cnt0 = 0;

  always #5 clk_i = ~clk_i;

  fifo_prog #(.WIDTH(16), .DEPTH(8), .MODE(FIFO_STD)) u_std8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_o(rdat[0]), .rd_valid_o(rval[0]),
    .wr_ack_o(ack[0]), .full_o(full[0]), .empty_o(empty[0]), .almost_full_o(afl[0]),
    .almost_empty_o(ael[0]), .af_thresh_i(af8), .ae_thresh_i(ae8), .level_o(lvl0),
    .overflow_o(ovf[0]), .underflow_o(unf[0]), .err_sticky_o(stk[0]), .err_clr_i(err_clr_i));

  fifo_prog #(.WIDTH(16), .DEPTH(6), .MODE(FIFO_STD)) u_std6 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_o(rdat[1]), .rd_valid_o(rval[1]),
    .wr_ack_o(ack[1]), .full_o(full[1]), .empty_o(empty[1]), .almost_full_o(afl[1]),
    .almost_empty_o(ael[1]), .af_thresh_i(af6), .ae_thresh_i(ae6), .level_o(lvl1),
    .overflow_o(ovf[1]), .underflow_o(unf[1]), .err_sticky_o(stk[1]), .err_clr_i(err_clr_i));

  fifo_prog #(.WIDTH(16), .DEPTH(8), .MODE(FIFO_FWFT)) u_fwft8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_o(rdat[2]), .rd_valid_o(rval[2]),
    .wr_ack_o(ack[2]), .full_o(full[2]), .empty_o(empty[2]), .almost_full_o(afl[2]),
    .almost_empty_o(ael[2]), .af_thresh_i(af8), .ae_thresh_i(ae8), .level_o(lvl2),
    .overflow_o(ovf[2]), .underflow_o(unf[2]), .err_sticky_o(stk[2]), .err_clr_i(err_clr_i));

  function automatic int dep(input int k);
    return (k == 1) ? 6 : 8;
  endfunction

  function automatic bit is_fwft(input int k);
    return k == 2;
  endfunction

  function automatic int th_af(input int k);
    return (k == 1) ? int'(af6) : int'(af8);
  endfunction

  function automatic int th_ae(input int k);
    return (k == 1) ? int'(ae6) : int'(ae8);
  endfunction

  function automatic logic [31:0] lvl_of(input int k);
    if (k == 0) return 32'(lvl0);
    if (k == 1) return 32'(lvl1);
    return 32'(lvl2);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Reference model: content held as an ordered list (index 0 = oldest).
  int          cnt   [NI];
  logic [15:0] md    [NI][8];
  logic [15:0] m_rdat[NI];
  bit          m_rval[NI];
  bit          m_ack [NI];
  bit          m_ovf [NI];
  bit          m_unf [NI];
  logic [1:0]  m_stk [NI];
  bit          w_ok, r_ok;

  always @(posedge clk_i or negedge rst_ni) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_ni) begin
        cnt[k] = 0; m_rdat[k] = 16'h0; m_rval[k] = 1'b0;
        m_ack[k] = 1'b0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_stk[k] = 2'b00;
      end else begin
        w_ok = wr_en_i && (cnt[k] < dep(k));
        r_ok = rd_en_i && (cnt[k] > 0);
        if (err_clr_i) m_stk[k] = 2'b00;
        if (flush_i) begin
          cnt[k] = 0; m_rval[k] = 1'b0;
          m_ack[k] = 1'b0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end else begin
          m_ack[k]  = w_ok;
          m_ovf[k]  = wr_en_i && !w_ok;
          m_unf[k]  = rd_en_i && !r_ok;
          m_rval[k] = r_ok;
          if (r_ok) begin
            m_rdat[k] = md[k][0];
            for (int j = 0; j < 7; j++) md[k][j] = md[k][j+1];
            cnt[k]--;
          end
          if (w_ok) begin
            md[k][cnt[k]] = wr_data_i;
            cnt[k]++;
          end
          m_stk[k] = m_stk[k] | {m_ovf[k], m_unf[k]};
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (ack[0]) ack_cnt0++;
      for (int k = 0; k < NI; k++) begin
        chk("level", k, lvl_of(k), 32'(cnt[k]));
        chk("full", k, 32'(full[k]), 32'(cnt[k] == dep(k)));
        chk("empty", k, 32'(empty[k]), 32'(cnt[k] == 0));
        chk("almost_full", k, 32'(afl[k]), 32'(cnt[k] >= th_af(k)));
        chk("almost_empty", k, 32'(ael[k]), 32'(cnt[k] <= th_ae(k)));
        chk("wr_ack", k, 32'(ack[k]), 32'(m_ack[k]));
        chk("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
        chk("underflow", k, 32'(unf[k]), 32'(m_unf[k]));
        chk("err_sticky", k, 32'(stk[k]), 32'(m_stk[k]));
        if (is_fwft(k)) begin
          chk("rd_valid", k, 32'(rval[k]), 32'(cnt[k] > 0));
          if (cnt[k] > 0) chk("rd_data", k, 32'(rdat[k]), 32'(md[k][0]));
        end else begin
          chk("rd_valid", k, 32'(rval[k]), 32'(m_rval[k]));
          chk("rd_data", k, 32'(rdat[k]), 32'(m_rdat[k]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) step();
    chk("rst_empty", 0, 32'(empty[0]), 32'd1);
    chk("rst_level", 0, 32'(lvl0), 32'd0);
    chk("rst_full", 0, 32'(full[0]), 32'd0);
    rst_ni = 1'b1;
    step();

    // Fill STD depth-8 with 1..8, then one overflowing write.
    ack_cnt0 = 0;
    for (int i = 1; i <= 8; i++) begin
      wr_en_i = 1'b1; wr_data_i = 16'(i);
      step();
    end
    wr_en_i = 1'b0;
    step();
    chk("fill_level", 0, 32'(lvl0), 32'd8);
    chk("fill_full", 0, 32'(full[0]), 32'd1);
    chk("fill_acks", 0, 32'(ack_cnt0), 32'd8);
    wr_en_i = 1'b1; wr_data_i = 16'h00FF;
    step();
    wr_en_i = 1'b0;
    chk("ovf_pulse", 0, 32'(ovf[0]), 32'd1);
    chk("ovf_sticky", 0, 32'(stk[0]), 32'd2);
    step();
    chk("ovf_one_cycle", 0, 32'(ovf[0]), 32'd0);

    // Drain in order, then one underflowing read.
    for (int i = 1; i <= 8; i++) begin
      rd_en_i = 1'b1;
      step();
      chk("drain_data", 0, 32'(rdat[0]), 32'(i));
      chk("drain_valid", 0, 32'(rval[0]), 32'd1);
    end
    rd_en_i = 1'b0;
    step();
    chk("valid_pulse_end", 0, 32'(rval[0]), 32'd0);
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("unf_pulse", 0, 32'(unf[0]), 32'd1);
    chk("unf_sticky", 0, 32'(stk[0][0]), 32'd1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("err_clear", 0, 32'(stk[0]), 32'd0);

    // Interleaved write/read pairs to wrap the depth-6 pointers.
    for (int i = 0; i < 20; i++) begin
      wr_en_i = 1'b1; rd_en_i = 1'b0; wr_data_i = 16'($urandom);
      step();
      wr_en_i = (i % 3) == 0; rd_en_i = 1'b1; wr_data_i = 16'($urandom);
      step();
    end
    wr_en_i = 1'b0; rd_en_i = 1'b0;

    // Threshold sweep on depth-8 with af=6, ae=2.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    af8 = 4'd6; ae8 = 4'd2;
    chk("flush_level", 0, 32'(lvl0), 32'd0);
    for (int l = 0; l <= 8; l++) begin
      chk("sweep_ae", l, 32'(ael[0]), 32'(l <= 2));
      chk("sweep_af", l, 32'(afl[0]), 32'(l >= 6));
      if (l == 4) begin
        af8 = 4'd3;
        #1;
        chk("af_retune", l, 32'(afl[0]), 32'd1);
        af8 = 4'd6;
      end
      if (l < 8) begin
        wr_en_i = 1'b1; wr_data_i = 16'(16'h100 + l);
        step();
      end
    end
    wr_en_i = 1'b0;

    // Flush at level 5 with a simultaneous write.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en_i = 1'b1; wr_data_i = 16'(i);
      step();
    end
    chk("pre_flush_level", 0, 32'(lvl0), 32'd5);
    flush_i = 1'b1; wr_en_i = 1'b1;
    step();
    flush_i = 1'b0; wr_en_i = 1'b0;
    chk("flush_lvl", 0, 32'(lvl0), 32'd0);
    chk("flush_empty", 0, 32'(empty[0]), 32'd1);
    chk("flush_no_ack", 0, 32'(ack[0]), 32'd0);

    // FWFT: a single word shows up without a read request.
    wr_en_i = 1'b1; wr_data_i = 16'hABCD;
    step();
    wr_en_i = 1'b0;
    chk("fwft_valid", 2, 32'(rval[2]), 32'd1);
    chk("fwft_data", 2, 32'(rdat[2]), 32'hABCD);
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("fwft_pop_empty", 2, 32'(empty[2]), 32'd1);

    // Randomised traffic with shifting bias, flushes, clears and retuning.
    for (int c = 0; c < 3000; c++) begin
      int wb, rb;
      wb = ((c / 200) % 3 == 0) ? 75 : (((c / 200) % 3 == 1) ? 30 : 50);
      rb = 100 - wb;
      wr_en_i   = $urandom_range(0, 99) < wb;
      rd_en_i   = $urandom_range(0, 99) < rb;
      wr_data_i = 16'($urandom);
      flush_i   = $urandom_range(0, 99) == 0;
      err_clr_i = !flush_i && ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        af8 = 4'($urandom_range(0, 15)); ae8 = 4'($urandom_range(0, 15));
        af6 = 3'($urandom_range(0, 7));  ae6 = 3'($urandom_range(0, 7));
      end
      if (c == 1500) begin
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_level", 0, 32'(lvl0), 32'd0);
        chk("arst_empty", 0, 32'(empty[0]), 32'd1);
        chk("arst_full", 0, 32'(full[0]), 32'd0);
        chk("arst_valid", 0, 32'(rval[0]), 32'd0);
        chk("arst_data", 0, 32'(rdat[0]), 32'd0);
        chk("arst_ack", 0, 32'(ack[0]), 32'd0);
        chk("arst_ovf", 0, 32'(ovf[0]), 32'd0);
        chk("arst_unf", 0, 32'(unf[0]), 32'd0);
        chk("arst_sticky", 0, 32'(stk[0]), 32'd0);
        chk("arst_fwft_valid", 2, 32'(rval[2]), 32'd0);
        step();
        rst_ni = 1'b1;
      end
      step();
    end
    wr_en_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
Parametrised next-generation synchronous FIFO: arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through (FWFT) read mode, runtime-programmable almost-full/almost-empty thresholds, fill-level output, synchronous flush and sticky error flags. Used as the general-purpose single-clock buffer between producer/consumer blocks. Flag semantics are unified so both read modes behave identically at the write side.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer)
MODE, FIFO_STD, read mode (fifo_pkg::fifo_mode_e: FIFO_STD or FIFO_FWFT)
LW, $clog2(DEPTH+1), derived width of level/threshold signals (localparam, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush: empties FIFO
wr_en_i  in  1  write request
wr_data_i  in  WIDTH  write data
rd_en_i  in  1  read request (FWFT: pop/acknowledge head)
rd_data_o  out  WIDTH  read data
rd_valid_o  out  1  rd_data_o valid
wr_ack_o  out  1  pulse: write accepted in previous cycle
full_o  out  1  level == DEPTH
empty_o  out  1  level == 0
almost_full_o  out  1  level >= af_thresh_i
almost_empty_o  out  1  level <= ae_thresh_i
af_thresh_i  in  LW  almost-full threshold
ae_thresh_i  in  LW  almost-empty threshold
level_o  out  LW  current occupancy
overflow_o  out  1  pulse: write rejected in previous cycle
underflow_o  out  1  pulse: read rejected in previous cycle
err_sticky_o  out  2  {overflow, underflow} sticky flags
err_clr_i  in  1  clears err_sticky_o

Behaviour:
- Reset (async, rst_ni=0): wr_ptr, rd_ptr, level=0; rd_data_o=0, rd_valid_o=0, wr_ack_o=0, overflow_o=0, underflow_o=0, err_sticky_o=0; empty_o=1, full_o=0. Memory contents not reset. Reset mid-operation discards all data.
- Accept rules evaluated on registered state at the rising edge: write accepted iff wr_en_i && !full_o; read accepted iff rd_en_i && !empty_o. Full + wr + rd: read accepted, write rejected (level DEPTH-1). Empty + wr + rd: write accepted, read rejected (level 1, underflow pulse).
- Level: +1 write only, -1 read only, unchanged both or neither.
- Pointers increment on accept; wrap from DEPTH-1 to 0 (explicit compare, not bit overflow).
- wr_ack_o/overflow_o/underflow_o: registered, 1 cycle after the request, one cycle long per event.
- err_sticky_o[1] set on rejected write, [0] on rejected read; cleared by err_clr_i; set wins over simultaneous clear.
- FIFO_STD: accepted read -> rd_data_o = head word registered, rd_valid_o=1 next cycle only; rd_data_o holds value otherwise.
- FIFO_FWFT: rd_data_o = mem[rd_ptr] combinationally, rd_valid_o = !empty_o; rd_en_i pops head; write into empty FIFO visible on rd_data_o the cycle after the write edge.
- flush_i: next edge level=0, pointers=0, rd_valid_o=0 (STD); same-cycle wr/rd dropped, no ack/overflow/underflow; sticky flags unaffected.
- Threshold compare combinational on registered level; thresholds may change any cycle; af_thresh_i > DEPTH => almost_full_o never asserts.

Decomposition:
- fifo_pkg: fifo_mode_e enum, function ptr_inc(ptr, depth) with wrap.
- Sub-module fifo_mem: DEPTH x WIDTH, one sync write port, one async read port; control, flags and output stage stay in fifo_prog.

Test Plan:
- STD, WIDTH=16, DEPTH=8: write 0x0001..0x0008 -> full_o=1, level_o=8, 8 wr_ack_o pulses; 9th write -> overflow_o pulse, err_sticky_o=2'b10, data unchanged.
- STD: read 8 times -> rd_data_o 0x0001..0x0008 each 1 cycle after rd_en_i with rd_valid_o pulse; 9th read -> underflow_o pulse, err_sticky_o[0]=1.
- DEPTH=6: 20 interleaved write/read pairs -> ptr wrap 5->0, data order preserved, level_o never exceeds 6.
- FWFT: write 0xABCD into empty -> next cycle rd_valid_o=1, rd_data_o=0xABCD without rd_en_i; rd_en_i -> empty_o=1.
- af_thresh_i=6, ae_thresh_i=2: fill 0->8 -> almost_empty_o high at levels 0..2, almost_full_o high at 6..8; change af to 3 at level 4 -> almost_full_o rises same cycle.
- Level 5, flush_i with wr_en_i=1 -> next cycle level_o=0, empty_o=1, no wr_ack_o; assert rst_ni mid-burst -> all outputs at reset values immediately.
